// File: rtl/axi4_slv_pkg.sv
// Shared types for the AXI4 slave memory.
//   resp_t     : AXI response encoding (OKAY, EXOKAY, SLVERR, DECERR)
//   wr_state_t : write-path FSM states
//   rd_state_t : read-path FSM states
//   beat_resp  : maps an error flag onto OKAY/SLVERR
package axi4_slv_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  function automatic resp_t beat_resp(input logic err);
    return err ? SLVERR : OKAY;
  endfunction

endpackage

// File: rtl/axi4_slv_mem_array.sv
// Simple dual-port word RAM: one byte-enabled write port, one registered
// read port. A read and a write to the same word in one cycle return the
// old contents (read-first). The read register holds its value while re=0
// so the bus payload stays stable during stalls.
// Ports:
//   clk, reset          : clock, synchronous active-high reset (read reg only)
//   we, waddr, wdata,
//   wstrb               : write port with byte enables
//   re, raddr, rzero    : read enable, read index, force read data to zero
//   rdata               : registered read data
module axi4_slv_mem_array #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int IDX_W      = $clog2(MEM_DEPTH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    we,
  input  logic [IDX_W-1:0]        waddr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    re,
  input  logic [IDX_W-1:0]        raddr,
  input  logic                    rzero,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem_r [0:MEM_DEPTH-1];
  logic [DATA_WIDTH-1:0] rdata_r;

  // Byte-enabled write port; storage is deliberately never cleared
  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
        if (wstrb[i]) begin
          mem_r[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
        end
      end
    end
  end

  // Registered read port; samples pre-write contents and holds when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
    end else if (re) begin
      rdata_r <= rzero ? {DATA_WIDTH{1'b0}} : mem_r[raddr];
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 slave memory: INCR bursts, one outstanding transaction per
// direction, independent concurrent read and write paths over a
// word-addressed array of MEM_DEPTH words. Byte offsets are ignored and
// the beat index wraps modulo MEM_DEPTH.
// Optional build macro AXI4_SLV_RANGE_CHECK_EN: beats whose unwrapped
// index is >= MEM_DEPTH are suppressed (writes dropped, reads return 0)
// and reported as SLVERR.
// Ports: clk, reset (sync active-high); AW (awaddr, awlen, awvalid,
// awready); W (wdata, wstrb, wlast, wvalid, wready); B (bresp, bvalid,
// bready); AR (araddr, arlen, arvalid, arready); R (rdata, rresp, rlast,
// rvalid, rready). All outputs are registered.
module axi4_slave_mem
  import axi4_slv_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic [7:0]              awlen,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wlast,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic [7:0]              arlen,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rlast,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int OFF_W = $clog2(DATA_WIDTH/8);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  // Unwrapped beat index: full word address plus one carry bit
  localparam int CNT_W = ADDR_WIDTH - OFF_W + 1;

  wr_state_t        wr_state_r;
  logic             awready_r, wready_r, bvalid_r, wr_err_r;
  resp_t            bresp_r;
  logic [CNT_W-1:0] wr_cnt_r;
  logic [7:0]       wr_left_r;

  rd_state_t        rd_state_r;
  logic             arready_r, rvalid_r, rlast_r;
  resp_t            rresp_r;
  logic [CNT_W-1:0] rd_cnt_r;
  logic [7:0]       rd_left_r;

  logic [CNT_W-1:0] aw_start_s, ar_start_s, rd_next_s;
  logic             wr_oor_s, ar_oor_s, rd_next_oor_s;
  logic             w_fire_s, w_final_s, w_beat_err_s;
  logic             mem_we_s, mem_re_s, mem_rzero_s;
  logic [IDX_W-1:0] mem_raddr_s;
  logic             unused_s;

  // Byte-offset bits and, without range checking, the upper index bits are ignored
  assign unused_s = ^{awaddr, araddr, wr_cnt_r, rd_cnt_r};

  // Beat indexing, range classification and write-beat qualification
  always_comb begin
    aw_start_s = {1'b0, awaddr[ADDR_WIDTH-1:OFF_W]};
    ar_start_s = {1'b0, araddr[ADDR_WIDTH-1:OFF_W]};
    rd_next_s  = rd_cnt_r + CNT_W'(1'b1);
`ifdef AXI4_SLV_RANGE_CHECK_EN
    wr_oor_s      = (wr_cnt_r   >= CNT_W'(MEM_DEPTH));
    ar_oor_s      = (ar_start_s >= CNT_W'(MEM_DEPTH));
    rd_next_oor_s = (rd_next_s  >= CNT_W'(MEM_DEPTH));
`else
    wr_oor_s      = 1'b0;
    ar_oor_s      = 1'b0;
    rd_next_oor_s = 1'b0;
`endif
    w_fire_s     = (wr_state_r == W_DATA) && wvalid && wready_r;
    w_final_s    = (wr_left_r == 8'd0);
    // wlast must match the awlen-defined final beat exactly
    w_beat_err_s = (wlast != w_final_s) || wr_oor_s;
    mem_we_s     = w_fire_s && !wr_oor_s && !reset;
  end

  // Read-port control: fetch the next beat one index ahead of the bus
  always_comb begin
    mem_re_s    = 1'b0;
    mem_raddr_s = rd_cnt_r[IDX_W-1:0];
    mem_rzero_s = 1'b0;
    case (rd_state_r)
      R_IDLE: begin
        if (arvalid && arready_r) begin
          mem_re_s    = 1'b1;
          mem_raddr_s = ar_start_s[IDX_W-1:0];
          mem_rzero_s = ar_oor_s;
        end else begin
          mem_re_s    = 1'b0;
        end
      end
      R_DATA: begin
        if (rvalid_r && rready && (rd_left_r != 8'd0)) begin
          mem_re_s    = 1'b1;
          mem_raddr_s = rd_next_s[IDX_W-1:0];
          mem_rzero_s = rd_next_oor_s;
        end else begin
          mem_re_s    = 1'b0;
        end
      end
      default: mem_re_s = 1'b0;
    endcase
  end

  axi4_slv_mem_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .MEM_DEPTH  (MEM_DEPTH),
    .IDX_W      (IDX_W)
  ) u_array (
    .clk   (clk),
    .reset (reset),
    .we    (mem_we_s),
    .waddr (wr_cnt_r[IDX_W-1:0]),
    .wdata (wdata),
    .wstrb (wstrb),
    .re    (mem_re_s),
    .raddr (mem_raddr_s),
    .rzero (mem_rzero_s),
    .rdata (rdata)
  );

  // Write FSM: AW latch, data beats, response hold
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_state_r <= W_IDLE;
      awready_r  <= 1'b1;
      wready_r   <= 1'b0;
      bvalid_r   <= 1'b0;
      bresp_r    <= OKAY;
      wr_cnt_r   <= {CNT_W{1'b0}};
      wr_left_r  <= 8'd0;
      wr_err_r   <= 1'b0;
    end else begin
      case (wr_state_r)
        W_IDLE: begin
          if (awvalid && awready_r) begin
            awready_r  <= 1'b0;
            wready_r   <= 1'b1;
            wr_cnt_r   <= aw_start_s;
            wr_left_r  <= awlen;
            wr_err_r   <= 1'b0;
            wr_state_r <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_fire_s) begin
            wr_cnt_r  <= wr_cnt_r + CNT_W'(1'b1);
            wr_left_r <= wr_left_r - 8'd1;
            if (w_final_s) begin
              wready_r   <= 1'b0;
              bvalid_r   <= 1'b1;
              bresp_r    <= beat_resp(wr_err_r || w_beat_err_s);
              wr_state_r <= W_RESP;
            end else begin
              wr_err_r   <= wr_err_r || w_beat_err_s;
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid_r   <= 1'b0;
            bresp_r    <= OKAY;
            awready_r  <= 1'b1;
            wr_state_r <= W_IDLE;
          end
        end
        default: begin
          wr_state_r <= W_IDLE;
          awready_r  <= 1'b1;
          wready_r   <= 1'b0;
          bvalid_r   <= 1'b0;
          bresp_r    <= OKAY;
        end
      endcase
    end
  end

  // Read FSM: AR latch, then one beat per R handshake with no bubbles
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_state_r <= R_IDLE;
      arready_r  <= 1'b1;
      rvalid_r   <= 1'b0;
      rlast_r    <= 1'b0;
      rresp_r    <= OKAY;
      rd_cnt_r   <= {CNT_W{1'b0}};
      rd_left_r  <= 8'd0;
    end else begin
      case (rd_state_r)
        R_IDLE: begin
          if (arvalid && arready_r) begin
            arready_r  <= 1'b0;
            rvalid_r   <= 1'b1;
            rlast_r    <= (arlen == 8'd0);
            rresp_r    <= beat_resp(ar_oor_s);
            rd_cnt_r   <= ar_start_s;
            rd_left_r  <= arlen;
            rd_state_r <= R_DATA;
          end
        end
        R_DATA: begin
          if (rvalid_r && rready) begin
            if (rd_left_r == 8'd0) begin
              rvalid_r   <= 1'b0;
              rlast_r    <= 1'b0;
              rresp_r    <= OKAY;
              arready_r  <= 1'b1;
              rd_state_r <= R_IDLE;
            end else begin
              rd_cnt_r   <= rd_next_s;
              rd_left_r  <= rd_left_r - 8'd1;
              rlast_r    <= (rd_left_r == 8'd1);
              rresp_r    <= beat_resp(rd_next_oor_s);
            end
          end
        end
        default: begin
          rd_state_r <= R_IDLE;
          arready_r  <= 1'b1;
          rvalid_r   <= 1'b0;
          rlast_r    <= 1'b0;
          rresp_r    <= OKAY;
        end
      endcase
    end
  end

  assign awready = awready_r;
  assign wready  = wready_r;
  assign bvalid  = bvalid_r;
  assign bresp   = bresp_r;
  assign arready = arready_r;
  assign rvalid  = rvalid_r;
  assign rlast   = rlast_r;
  assign rresp   = rresp_r;

endmodule
